// File: rtl/decode_stage_if.sv
// Bus bundle for the Quinta ID stage: fetch handshake, register-file read,
// writeback snoop and the ID/EX valid/ready output register.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;
  logic [4:0]      read1_id;
  logic [4:0]      read2_id;
  logic [XLEN-1:0] read1_data;
  logic [XLEN-1:0] read2_data;
  logic            wb_en;
  logic [4:0]      wb_id;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_is_load;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, read1_data, read2_data,
           wb_en, wb_id, wb_data, out_ready,
    output in_ready, read1_id, read2_id, out_valid, out_pc, out_instr,
           out_rs1_data, out_rs2_data, out_rd, out_imm, out_is_load
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, read1_data, read2_data,
           wb_en, wb_id, wb_data, out_ready,
    input  in_ready, read1_id, read2_id, out_valid, out_pc, out_instr,
           out_rs1_data, out_rs2_data, out_rd, out_imm, out_is_load
  );
endinterface

// File: rtl/decode_stage.sv
// Quinta RV32I decode stage: field split, immediate generation, load-use stall and
// ID/EX register. Define DECODE_WB_BYPASS_EN to bypass writeback data on accept.
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic signed [XLEN-1:0] sext_imm(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0]            instr;
  logic [6:0]             opcode;
  logic [4:0]             rs1_id;
  logic [4:0]             rs2_id;
  logic [4:0]             rd_d;
  logic                   uses_rs1;
  logic                   uses_rs2;
  logic                   is_load_d;
  logic signed [31:0]     imm32;
  logic signed [XLEN-1:0] imm_d;

  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [31:0]            instr_p1;
  logic signed [XLEN-1:0] rs1_p1;
  logic signed [XLEN-1:0] rs2_p1;
  logic [4:0]             rd_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic                   is_load_p1;
  logic                   shadow_vld;
  logic [4:0]             shadow_rd;

  logic                   rs1_used;
  logic                   rs2_used;
  logic                   held_load;
  logic                   ld_hit1;
  logic                   ld_hit2;
  logic                   wb_hit1;
  logic                   wb_hit2;
  logic                   hazard;
  logic                   in_ready;
  logic                   accept;
  logic                   fire;
  logic                   hold;
  logic                   refresh1;
  logic                   refresh2;
  logic signed [XLEN-1:0] op1_d;
  logic signed [XLEN-1:0] op2_d;

  assign instr         = bus.in_instr;
  assign opcode        = instr[6:0];
  assign rs1_id        = instr[19:15];
  assign rs2_id        = instr[24:20];
  assign bus.read1_id  = rs1_id;
  assign bus.read2_id  = rs2_id;
  assign is_load_d     = (opcode == OPC_LOAD);
  assign imm_d         = sext_imm(imm32);

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    rd_d     = instr[11:7];
    imm32    = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
      OPC_JAL:            imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rs1 = 1'b1;
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        rd_d     = 5'd0;
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        rd_d     = 5'd0;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // x0 is excluded here so it can never stall or bypass
  assign rs1_used  = uses_rs1 && (rs1_id != 5'd0);
  assign rs2_used  = uses_rs2 && (rs2_id != 5'd0);
  assign held_load = vld_p1 && is_load_p1;
  assign ld_hit1   = rs1_used && ((held_load && rs1_id == rd_p1) || (shadow_vld && rs1_id == shadow_rd));
  assign ld_hit2   = rs2_used && ((held_load && rs2_id == rd_p1) || (shadow_vld && rs2_id == shadow_rd));
  assign wb_hit1   = bus.wb_en && rs1_used && (bus.wb_id == rs1_id);
  assign wb_hit2   = bus.wb_en && rs2_used && (bus.wb_id == rs2_id);

`ifdef DECODE_WB_BYPASS_EN
  assign hazard = ld_hit1 || ld_hit2;
  assign op1_d  = wb_hit1 ? bus.wb_data : bus.read1_data;
  assign op2_d  = wb_hit2 ? bus.wb_data : bus.read2_data;
`else
  // Without the bypass a same-cycle writeback is waited out for one cycle
  assign hazard = ld_hit1 || ld_hit2 || wb_hit1 || wb_hit2;
  assign op1_d  = bus.read1_data;
  assign op2_d  = bus.read2_data;
`endif

  assign in_ready     = !bus.flush && (!vld_p1 || bus.out_ready) && !hazard;
  assign bus.in_ready = in_ready;
  assign accept       = bus.in_valid && in_ready;
  assign fire         = vld_p1 && bus.out_ready;
  assign hold         = vld_p1 && !bus.out_ready;
  assign refresh1     = hold && bus.wb_en && (bus.wb_id != 5'd0) && (bus.wb_id == instr_p1[19:15]);
  assign refresh2     = hold && bus.wb_en && (bus.wb_id != 5'd0) && (bus.wb_id == instr_p1[24:20]);

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      instr_p1   <= NOP_INSTR;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      imm_p1     <= '0;
      is_load_p1 <= 1'b0;
      shadow_vld <= 1'b0;
      shadow_rd  <= '0;
    end else begin
      shadow_vld <= !bus.flush && fire && is_load_p1;
      if (fire && is_load_p1)
        shadow_rd <= rd_p1;

      if (bus.flush)
        vld_p1 <= 1'b0;
      else if (accept)
        vld_p1 <= 1'b1;
      else if (fire)
        vld_p1 <= 1'b0;

      if (accept) begin
        pc_p1      <= bus.in_pc;
        instr_p1   <= instr;
        rs1_p1     <= op1_d;
        rs2_p1     <= op2_d;
        rd_p1      <= rd_d;
        imm_p1     <= imm_d;
        is_load_p1 <= is_load_d;
      end else begin
        if (refresh1)
          rs1_p1 <= bus.wb_data;
        if (refresh2)
          rs2_p1 <= bus.wb_data;
      end
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.out_pc       = pc_p1;
  assign bus.out_instr    = instr_p1;
  assign bus.out_rs1_data = rs1_p1;
  assign bus.out_rs2_data = rs2_p1;
  assign bus.out_rd       = rd_p1;
  assign bus.out_imm      = imm_p1;
  assign bus.out_is_load  = is_load_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011,
                         OP_OP = 7'b0110011, OP_STORE = 7'b0100011, OP_BR = 7'b1100011,
                         OP_SYS = 7'b1110011;
  localparam logic [31:0] I_ADDI = 32'hFFC08293;  // addi x5,x1,-4
  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A203;  // lw x4,0(x1)
  localparam logic [31:0] I_DEP  = 32'h00420333;  // add x6,x4,x4

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN)) bus ();
  decode_stage #(.XLEN(XLEN), .NOP_INSTR(32'h00000013)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] rf [32];
  assign bus.read1_data = (bus.read1_id == 5'd0) ? 32'd0 : rf[bus.read1_id];
  assign bus.read2_data = (bus.read2_id == 5'd0) ? 32'd0 : rf[bus.read2_id];

  int checks = 0;
  int errors = 0;

  // reference model: one held transaction plus a cycle-stamped load block
  logic        m_vld = 1'b0;
  logic [31:0] m_pc = '0, m_instr = 32'h13, m_rs1 = '0, m_rs2 = '0;
  int          cyc = 0;
  int          blk_cyc = -1;
  logic [4:0]  blk_rd = '0;
  logic        exp_ready = 1'b0, act_ready = 1'b0;

  function automatic bit uses1(logic [31:0] i);
    case (i[6:0])
      OP_JALR, OP_LOAD, OP_IMM, OP_OP, OP_STORE, OP_BR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit uses2(logic [31:0] i);
    case (i[6:0])
      OP_OP, OP_STORE, OP_BR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] rd_of(logic [31:0] i);
    if (i[6:0] == OP_STORE || i[6:0] == OP_BR) return 5'd0;
    return i[11:7];
  endfunction

  function automatic bit is_load_of(logic [31:0] i);
    return i[6:0] == OP_LOAD;
  endfunction

  // immediates from weighted bit fields, sign bit as a negative power of two
  function automatic logic [31:0] imm_of(logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      OP_LUI, OP_AUIPC: v = int'(i[31:12]) << 12;
      OP_JAL:  v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                   + int'(i[30:21]) * 2;
      OP_JALR, OP_LOAD, OP_IMM: v = (i[31] ? -2048 : 0) + int'(i[30:20]);
      OP_STORE: v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
      OP_BR:   v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                   + int'(i[11:8]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic tick();
    logic [31:0] i, pc, wbd;
    logic [4:0]  r1, r2, wbi;
    logic        hz, acc, fire, hit1, hit2, fl, ordy, wbe, r;
    @(negedge clk);
    i = bus.in_instr; pc = bus.in_pc; fl = bus.flush; ordy = bus.out_ready;
    wbe = bus.wb_en; wbi = bus.wb_id; wbd = bus.wb_data; r = rst;
    r1 = i[19:15]; r2 = i[24:20];
    hz = 1'b0;
    if (uses1(i) && r1 != 0) begin
      if (m_vld && is_load_of(m_instr) && rd_of(m_instr) == r1) hz = 1'b1;
      if (blk_cyc == cyc && blk_rd == r1) hz = 1'b1;
    end
    if (uses2(i) && r2 != 0) begin
      if (m_vld && is_load_of(m_instr) && rd_of(m_instr) == r2) hz = 1'b1;
      if (blk_cyc == cyc && blk_rd == r2) hz = 1'b1;
    end
    hit1 = wbe && wbi != 0 && uses1(i) && r1 == wbi;
    hit2 = wbe && wbi != 0 && uses2(i) && r2 == wbi;
`ifndef DECODE_WB_BYPASS_EN
    if (hit1 || hit2) hz = 1'b1;
`endif
    exp_ready = !fl && (!m_vld || ordy) && !hz;
    act_ready = bus.in_ready;
    acc  = bus.in_valid && exp_ready;
    fire = m_vld && ordy;
    @(posedge clk);
    #1;
    if (r) begin
      m_vld = 1'b0; m_pc = '0; m_instr = 32'h13; m_rs1 = '0; m_rs2 = '0; blk_cyc = -1;
    end else begin
      if (fl) blk_cyc = -1;
      else if (fire && is_load_of(m_instr)) begin
        blk_rd = rd_of(m_instr); blk_cyc = cyc + 1;
      end
      if (acc) begin
        m_vld = 1'b1; m_pc = pc; m_instr = i;
        m_rs1 = (r1 == 0) ? 32'd0 : rf[r1];
        m_rs2 = (r2 == 0) ? 32'd0 : rf[r2];
`ifdef DECODE_WB_BYPASS_EN
        if (hit1) m_rs1 = wbd;
        if (hit2) m_rs2 = wbd;
`endif
      end else if (fl || fire) begin
        m_vld = 1'b0;
      end else if (m_vld && wbe && wbi != 0) begin
        if (wbi == m_instr[19:15]) m_rs1 = wbd;
        if (wbi == m_instr[24:20]) m_rs2 = wbd;
      end
    end
    if (wbe && wbi != 0) rf[wbi] = wbd;
    cyc++;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = 32'h13; bus.flush = 0;
    bus.wb_en = 0; bus.wb_id = '0; bus.wb_data = '0; bus.out_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", bus.out_instr); end
    checks++; if ({bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_imm, bus.out_rd, bus.out_is_load} !== '0) begin
      errors++; $display("FAIL reset_zero: pc %h rs1 %h rs2 %h imm %h rd %0d ld %0b want all 0",
                         bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_imm, bus.out_rd, bus.out_is_load);
    end
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_addi();
    rf[1] = 32'd10;
    bus.in_instr = I_ADDI; bus.in_pc = 32'h100; bus.in_valid = 1; bus.out_ready = 0;
    tick();
    checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL addi_ready: got %0b want 1", act_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_rs1_data !== 32'd10) begin errors++; $display("FAIL addi_rs1: got %h want 0000000a", bus.out_rs1_data); end
    checks++; if (bus.out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL addi_imm: got %h want fffffffc", bus.out_imm); end
    checks++; if (bus.out_rd !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d want 5", bus.out_rd); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h want 00000100", bus.out_pc); end
    bus.in_valid = 0; bus.out_ready = 1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_bypass();
    rf[1] = 32'd3; rf[2] = 32'h11;
    bus.in_instr = I_ADD; bus.in_pc = 32'h104; bus.in_valid = 1; bus.out_ready = 1;
    bus.wb_en = 1; bus.wb_id = 5'd2; bus.wb_data = 32'h55;
    tick();
`ifdef DECODE_WB_BYPASS_EN
    checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %0b want 1", act_ready); end
`else
    checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL byp_stall: got %0b want 0", act_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL byp_novalid: got %0b want 0", bus.out_valid); end
    bus.wb_en = 0;
    tick();
    checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL byp_ready2: got %0b want 1", act_ready); end
`endif
    bus.wb_en = 0; bus.in_valid = 0; bus.out_ready = 0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_rs2_data !== 32'h55) begin errors++; $display("FAIL byp_rs2: got %h want 00000055", bus.out_rs2_data); end
    checks++; if (bus.out_rs1_data !== 32'd3) begin errors++; $display("FAIL byp_rs1: got %h want 00000003", bus.out_rs1_data); end
  endtask

  task automatic test_hold_refresh();
    logic [31:0] pc0, imm0;
    pc0 = 32'h104; imm0 = 32'h0;
    bus.out_ready = 0; bus.in_valid = 0; bus.wb_en = 0;
    tick();
    checks++; if (bus.out_rs1_data !== 32'd3) begin errors++; $display("FAIL hold_c1_rs1: got %h want 00000003", bus.out_rs1_data); end
    bus.wb_en = 1; bus.wb_id = 5'd1; bus.wb_data = 32'd7;
    tick();
    checks++; if (bus.out_rs1_data !== 32'd7) begin errors++; $display("FAIL hold_c2_rs1: got %h want 00000007", bus.out_rs1_data); end
    bus.wb_en = 0;
    tick();
    checks++; if (bus.out_rs1_data !== 32'd7) begin errors++; $display("FAIL hold_c3_rs1: got %h want 00000007", bus.out_rs1_data); end
    checks++; if (bus.out_pc !== pc0) begin errors++; $display("FAIL hold_pc: got %h want %h", bus.out_pc, pc0); end
    checks++; if (bus.out_imm !== imm0) begin errors++; $display("FAIL hold_imm: got %h want %h", bus.out_imm, imm0); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %0b want 1", bus.out_valid); end
    bus.out_ready = 1;
    tick();
  endtask

  task automatic test_load_use();
    int stall;
    bit got;
    stall = 0; got = 0;
    bus.out_ready = 1; bus.wb_en = 0; bus.in_valid = 1;
    bus.in_instr = I_LW; bus.in_pc = 32'h200;
    tick();
    checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL lu_lw_ready: got %0b want 1", act_ready); end
    bus.in_instr = I_DEP; bus.in_pc = 32'h204;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (act_ready) got = 1; else stall++;
    end
    bus.in_valid = 0;
    checks++; if (!got || stall != 2) begin errors++; $display("FAIL lu_bubbles: got %0d stall cycles (accepted %0b) want 2", stall, got); end
    checks++; if (bus.out_instr !== I_DEP || bus.out_rs1_data !== m_rs1) begin
      errors++; $display("FAIL lu_dep: got instr %h rs1 %h want %h %h", bus.out_instr, bus.out_rs1_data, I_DEP, m_rs1);
    end
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 0; bus.in_valid = 1; bus.in_instr = I_LW; bus.in_pc = 32'h300;
    tick();
    bus.flush = 1; bus.out_ready = 1; bus.in_instr = I_DEP; bus.in_pc = 32'h304;
    tick();
    checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL fl_ready: got %0b want 0", act_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %0b want 0", bus.out_valid); end
    bus.flush = 0;
    tick();
    checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL fl_shadow: got %0b want 1", act_ready); end
    bus.out_ready = 0; bus.in_instr = I_ADDI; bus.in_pc = 32'h308; bus.flush = 1;
    tick();
    checks++; if (act_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL fl_held: got ready %0b valid %0b want 0 0", act_ready, bus.out_valid);
    end
    bus.flush = 0; bus.in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  ops [10];
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP, OP_STORE, OP_BR, OP_SYS};
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      bus.in_instr  = ins;
      bus.in_pc     = $urandom;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.wb_en     = 1'($urandom_range(0, 1));
      bus.wb_id     = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      #1;
      checks++; if (bus.read1_id !== ins[19:15] || bus.read2_id !== ins[24:20]) begin
        errors++; $display("FAIL rnd_ids: got %0d %0d want %0d %0d", bus.read1_id, bus.read2_id, ins[19:15], ins[24:20]);
      end
      tick();
      checks++; if (act_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d: got %0b want %0b", cyc, act_ready, exp_ready); end
      checks++; if (bus.out_valid !== m_vld) begin errors++; $display("FAIL rnd_valid cyc %0d: got %0b want %0b", cyc, bus.out_valid, m_vld); end
      if (m_vld) begin
        checks++; if (bus.out_pc !== m_pc || bus.out_instr !== m_instr) begin
          errors++; $display("FAIL rnd_pc_instr cyc %0d: got %h %h want %h %h", cyc, bus.out_pc, bus.out_instr, m_pc, m_instr);
        end
        checks++; if (bus.out_rs1_data !== m_rs1 || bus.out_rs2_data !== m_rs2) begin
          errors++; $display("FAIL rnd_ops cyc %0d: got %h %h want %h %h", cyc, bus.out_rs1_data, bus.out_rs2_data, m_rs1, m_rs2);
        end
        checks++; if (bus.out_rd !== rd_of(m_instr) || bus.out_imm !== imm_of(m_instr) || bus.out_is_load !== is_load_of(m_instr)) begin
          errors++; $display("FAIL rnd_dec cyc %0d: got rd %0d imm %h ld %0b want %0d %h %0b", cyc, bus.out_rd, bus.out_imm,
                             bus.out_is_load, rd_of(m_instr), imm_of(m_instr), is_load_of(m_instr));
        end
      end
    end
    bus.in_valid = 0; bus.flush = 0; bus.wb_en = 0;
  endtask

  initial begin
    rf[0] = '0;
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    test_reset();
    test_addi();
    test_bypass();
    test_hold_refresh();
    test_load_use();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
